sll_serial: RTL and testbench

Iterative logical-left shifter: the left-shift counterpart to the datapath's one-bit arithmetic-right-shift stage. It accepts a 32-bit operand and a 5-bit shift amount, then shifts left one bit per clock until the amount is consumed. It returns the result with a one-cycle valid pulse and a flag recording any nonzero bits shifted out. It sits beside the ALU as a low-area multi-cycle shift unit.

---
 rtl/sll_serial.sv | 72 +++++++
 tb/tb_sll_serial.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sll_serial.sv
// Iterative logical-left shifter: one bit per clock, zero fill, with a sticky
// flag recording whether any nonzero bit left the top of the register.
module sll_serial #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               ready,
  output logic               busy,
  output logic [WIDTH-1:0]   result,
  output logic               result_valid,
  output logic               bits_lost,
  output logic [1:0]         state_dbg
);

  // Handshake: a request is taken on a rising edge where start=1 and ready=1;
  // result_valid pulses for one cycle and is not back-pressured.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   sreg;
  logic [SHAMT_W-1:0] cnt;
  logic               lost;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
      lost  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sreg  <= data_in;
            cnt   <= shamt;
            lost  <= 1'b0;
            state <= (shamt == '0) ? DONE : SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          sreg <= {sreg[WIDTH-2:0], 1'b0};
          lost <= lost | sreg[WIDTH-1];
          cnt  <= cnt - SHAMT_W'(1);
          // SHIFT is only entered with cnt>=1, so the counter cannot wrap.
          if (cnt == SHAMT_W'(1)) begin
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready        = (state != SHIFT);
  assign busy         = (state == SHIFT);
  assign result_valid = (state == DONE);
  assign result       = sreg;
  assign bits_lost    = lost;
  assign state_dbg    = state;

endmodule

// File: tb/tb_sll_serial.sv
// Randomized scoreboard bench for sll_serial: drivers push expected results
// and completion cycles, a negedge monitor pops and compares on result_valid.
module tb_sll_serial;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  logic               clock;
  logic               reset;
  logic               start;
  logic [WIDTH-1:0]   data_in;
  logic [SHAMT_W-1:0] shamt;
  logic               ready;
  logic               busy;
  logic [WIDTH-1:0]   result;
  logic               result_valid;
  logic               bits_lost;
  logic [1:0]         state_dbg;

  sll_serial #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .data_in      (data_in),
    .shamt        (shamt),
    .ready        (ready),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .bits_lost    (bits_lost),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // scoreboard state
  logic [WIDTH:0] exp_q[$];
  int             exp_cyc_q[$];
  int             compared   = 0;
  int             mismatched = 0;
  int             busy_lo    = 1;
  int             busy_hi    = 0;
  int             results_seen = 0;
  logic [WIDTH:0] last_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: shift the zero-extended operand in a wide word; whatever lands
  // above the operand width is what got shifted out.
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] d, input int n);
    logic [2*WIDTH-1:0] w;
    w = {{WIDTH{1'b0}}, d} << n;
    return {|w[2*WIDTH-1:WIDTH], w[WIDTH-1:0]};
  endfunction

  // monitor
  always @(negedge clock) begin
    if (reset) begin
      check("busy_window", {63'b0, busy}, {63'b0, (cyc >= busy_lo && cyc <= busy_hi)});
      check("ready_vs_busy", {63'b0, ready}, {63'b0, ~busy});
      if (result_valid) begin
        results_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 64'd1, 64'd0);
        end else begin
          logic [WIDTH:0] e;
          int ec;
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check("result", {32'b0, result}, {32'b0, e[WIDTH-1:0]});
          check("bits_lost", {63'b0, bits_lost}, {63'b0, e[WIDTH]});
          check("latency", 64'(cyc), 64'(ec));
        end
      end
    end
  end

  // driver: wait for ready, present request, push expectation at acceptance
  task automatic run_op(input logic [WIDTH-1:0] d, input int n, input bit keep);
    int waited = 0;
    @(negedge clock);
    while (!ready && waited < 100) begin
      @(negedge clock);
      waited++;
    end
    if (!ready) check("ready_timeout", 64'd0, 64'd1);
    start   = 1'b1;
    data_in = d;
    shamt   = SHAMT_W'(n);
    @(posedge clock);
    #1;
    exp_q.push_back(model(d, n));
    exp_cyc_q.push_back(cyc + n);
    last_exp = model(d, n);
    busy_lo  = cyc;
    busy_hi  = cyc + n - 1;
    if (!keep) start = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(negedge clock);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {63'b0, ready}, 64'd1);
    check({tag, "_busy"}, {63'b0, busy}, 64'd0);
    check({tag, "_result"}, {32'b0, result}, 64'd0);
    check({tag, "_valid"}, {63'b0, result_valid}, 64'd0);
    check({tag, "_lost"}, {63'b0, bits_lost}, 64'd0);
    check({tag, "_state"}, {62'b0, state_dbg}, 64'd0);
  endtask

  initial begin
    int seen_before;
    start   = 1'b0;
    data_in = '0;
    shamt   = '0;
    reset   = 1'b0;
    #1;
    check_reset_outputs("reset_async");
    // start is ignored while reset is held
    start = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("reset_held");
    start = 1'b0;
    @(negedge clock);
    reset = 1'b1;

    // directed cases
    run_op(32'hDEADBEEF, 0, 1'b0);
    drain();
    run_op(32'h00000001, 31, 1'b0);
    drain();
    run_op(32'hF000000F, 4, 1'b0);
    drain();
    repeat (3) @(negedge clock);
    check("idle_hold_result", {32'b0, result}, {32'b0, last_exp[WIDTH-1:0]});
    check("idle_hold_lost", {63'b0, bits_lost}, {63'b0, last_exp[WIDTH]});

    // back-to-back with start held high
    run_op(32'h00000003, 2, 1'b1);
    run_op(32'h80000001, 1, 1'b0);
    drain();

    // start pulses during SHIFT must be ignored
    run_op(32'h12345678, 10, 1'b0);
    repeat (3) @(negedge clock);
    start = 1'b1; data_in = 32'hFFFFFFFF; shamt = 5'd1;
    repeat (2) @(negedge clock);
    start = 1'b0;
    drain();

    // reset mid-shift aborts without a result
    run_op(32'hA5A5A5A5, 10, 1'b0);
    repeat (3) @(posedge clock);
    #2;
    seen_before = results_seen;
    reset = 1'b0;
    #1;
    check_reset_outputs("reset_abort");
    exp_q.delete();
    exp_cyc_q.delete();
    busy_lo = 1;
    busy_hi = 0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    check("abort_no_valid", 64'(results_seen), 64'(seen_before));
    run_op(32'h00000001, 5, 1'b0);
    drain();

    // randomized operations, random gaps, random back-to-back
    for (int i = 0; i < 60; i++) begin
      bit keep;
      keep = ($urandom_range(0, 3) == 0) && (i != 59);
      run_op($urandom, $urandom_range(0, 31), keep);
      if (!keep) repeat ($urandom_range(0, 2)) @(negedge clock);
    end
    drain();
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
